// File: rtl/sprite_draw_scheduler.sv
// Round-robin rectangle fill scheduler for the single vga_adapter
// pixel port, with a strict-priority full-screen clear.
module sprite_draw_scheduler #(
  parameter int NREQ  = 4,
  parameter int WB    = 4,
  parameter int HB    = 4,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] rect_x,
  input  logic [NREQ*7-1:0] rect_y,
  input  logic [NREQ*WB-1:0] rect_w,
  input  logic [NREQ*HB-1:0] rect_h,
  input  logic [NREQ*3-1:0] rect_colour,
  input  logic              clear_req,
  input  logic [2:0]        clear_colour,
  output logic [NREQ-1:0]   grant,
  output logic              clear_busy,
  output logic [NREQ-1:0]   done,
  output logic              clear_done,
  output logic              busy,
  output logic [7:0]        x,
  output logic [6:0]        y,
  output logic [2:0]        colour,
  output logic              plot
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAW,
    CLEAR
  } state_t;

  state_t state, state_n;

  logic [PW-1:0] ptr, ptr_n;
  logic [PW-1:0] owner, owner_n;
  logic [PW-1:0] win;
  logic          win_any;
  logic [7:0]    lx, lx_n;
  logic [6:0]    ly, ly_n;
  logic [WB-1:0] lw, lw_n;
  logic [HB-1:0] lh, lh_n;
  logic [7:0]    cx, cx_n;
  logic [6:0]    cy, cy_n;
  logic          draw_last;
  logic          clear_last;

  logic [NREQ-1:0] grant_n, done_n;
  logic            clear_done_n, clear_busy_n;
  logic            busy_n, plot_n;
  logic [7:0]      x_n;
  logic [6:0]      y_n;
  logic [2:0]      colour_n;

  logic       pix_en;
  logic [7:0] bx;
  logic [6:0] by;
  logic [8:0] px, py;

  // First set request at or above ptr, wrapping.
  always_comb begin
    int ti;
    logic [PW-1:0] cand;
    win_any = 1'b0;
    win     = '0;
    ti      = 0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      ti = int'(ptr) + k;
      if (ti >= NREQ) ti = ti - NREQ;
      cand = PW'(ti);
      if (!win_any && req[cand]) begin
        win_any = 1'b1;
        win     = cand;
      end
    end
  end

  assign draw_last  = (cx == 8'(lw)) && (cy == 7'(lh));
  assign clear_last = (cx == 8'(SCR_W - 1)) &&
                      (cy == 7'(SCR_H - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (clear_req)    state_n = CLEAR;
        else if (win_any) state_n = DRAW;
      end
      DRAW:    if (draw_last)  state_n = IDLE;
      CLEAR:   if (clear_last) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ptr_n        = ptr;
    owner_n      = owner;
    lx_n         = lx;
    ly_n         = ly;
    lw_n         = lw;
    lh_n         = lh;
    cx_n         = cx;
    cy_n         = cy;
    grant_n      = grant;
    done_n       = '0;
    clear_done_n = 1'b0;
    clear_busy_n = clear_busy;
    busy_n       = busy;
    x_n          = x;
    y_n          = y;
    colour_n     = colour;
    plot_n       = 1'b0;
    pix_en       = 1'b0;
    bx           = lx;
    by           = ly;
    unique case (state)
      IDLE: begin
        grant_n      = '0;
        busy_n       = 1'b0;
        clear_busy_n = 1'b0;
        if (clear_req) begin
          cx_n         = '0;
          cy_n         = '0;
          x_n          = '0;
          y_n          = '0;
          colour_n     = clear_colour;
          plot_n       = 1'b1;
          clear_busy_n = 1'b1;
          busy_n       = 1'b1;
        end else if (win_any) begin
          lx_n     = rect_x[int'(win)*8 +: 8];
          ly_n     = rect_y[int'(win)*7 +: 7];
          lw_n     = rect_w[int'(win)*WB +: WB];
          lh_n     = rect_h[int'(win)*HB +: HB];
          colour_n = rect_colour[int'(win)*3 +: 3];
          owner_n  = win;
          ptr_n    = (win == PW'(NREQ - 1)) ?
                     '0 : win + PW'(1);
          grant_n  = NREQ'(1) << win;
          busy_n   = 1'b1;
          cx_n     = '0;
          cy_n     = '0;
          bx       = lx_n;
          by       = ly_n;
          pix_en   = 1'b1;
        end
      end
      DRAW: begin
        if (draw_last) begin
          done_n  = NREQ'(1) << owner;
          grant_n = '0;
          busy_n  = 1'b0;
        end else begin
          if (cx == 8'(lw)) begin
            cx_n = '0;
            cy_n = cy + 7'd1;
          end else begin
            cx_n = cx + 8'd1;
          end
          pix_en = 1'b1;
        end
      end
      CLEAR: begin
        if (clear_last) begin
          clear_done_n = 1'b1;
          clear_busy_n = 1'b0;
          busy_n       = 1'b0;
        end else begin
          if (cx == 8'(SCR_W - 1)) begin
            cx_n = '0;
            cy_n = cy + 7'd1;
          end else begin
            cx_n = cx + 8'd1;
          end
          x_n    = cx_n;
          y_n    = cy_n;
          plot_n = 1'b1;
        end
      end
      default: ;
    endcase
    // 9-bit sums so off-screen pixels are suppressed, not wrapped.
    px = {1'b0, bx} + {1'b0, cx_n};
    py = {2'b0, by} + {2'b0, cy_n};
    if (pix_en) begin
      x_n    = px[7:0];
      y_n    = py[6:0];
      plot_n = (px < 9'(SCR_W)) && (py < 9'(SCR_H));
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr        <= '0;
      owner      <= '0;
      lx         <= '0;
      ly         <= '0;
      lw         <= '0;
      lh         <= '0;
      cx         <= '0;
      cy         <= '0;
      grant      <= '0;
      done       <= '0;
      clear_done <= 1'b0;
      clear_busy <= 1'b0;
      busy       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
    end else begin
      ptr        <= ptr_n;
      owner      <= owner_n;
      lx         <= lx_n;
      ly         <= ly_n;
      lw         <= lw_n;
      lh         <= lh_n;
      cx         <= cx_n;
      cy         <= cy_n;
      grant      <= grant_n;
      done       <= done_n;
      clear_done <= clear_done_n;
      clear_busy <= clear_busy_n;
      busy       <= busy_n;
      x          <= x_n;
      y          <= y_n;
      colour     <= colour_n;
      plot       <= plot_n;
    end
  end

endmodule
